// File: rtl/sm_run_ctrl.sv
// Run/step/breakpoint controller for the schoolMIPS core: gates the CPU clock
// enable and sequences free run, halt, N-cycle stepping and PC breakpoints.
module sm_run_ctrl #(
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 16,
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic [1:0]          cmdOp,
    input  logic [31:0]         cmdArg,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                cpuEn,
    output logic                halted,
    output logic                bpHit,
    output logic [31:0]         cycleCnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_SETBP = 2'b11;

    localparam state_t RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  step_left_reg, step_left_next;
    logic [PC_WIDTH-1:0]   bp_addr_reg, bp_addr_next;
    logic                  bp_en_reg, bp_en_next;
    logic                  bp_armed_reg, bp_armed_next;
    logic                  bp_hit_reg, bp_hit_next;
    logic [31:0]           cycle_cnt_reg, cycle_cnt_next;

    logic                  cmd_accept;
    logic                  bp_match;
    logic                  cpu_en_int;
    logic [CNT_WIDTH-1:0]  step_arg;
    logic [PC_WIDTH-1:0]   bp_arg;

    assign step_arg   = cmdArg[CNT_WIDTH-1:0];
    assign bp_arg     = cmdArg[PC_WIDTH-1:0];
    assign cmd_accept = cmdValid & cmdReady;
    assign bp_match   = bp_en_reg & bp_armed_reg & (pc == bp_addr_reg);
    assign cpu_en_int = ((state_reg == ST_RUN) & ~bp_match) | (state_reg == ST_STEP);

    // The enable is masked by rst directly so the CPU freezes even when the
    // block resets into RUN.
    assign cpuEn    = cpu_en_int & ~rst;
    assign cmdReady = (state_reg != ST_STEP);
    assign halted   = (state_reg == ST_HALT);
    assign bpHit    = bp_hit_reg;
    assign cycleCnt = cycle_cnt_reg;

    always_comb begin
        state_next     = state_reg;
        step_left_next = step_left_reg;
        bp_addr_next   = bp_addr_reg;
        bp_en_next     = bp_en_reg;
        bp_armed_next  = bp_armed_reg;
        bp_hit_next    = bp_hit_reg;
        cycle_cnt_next = cycle_cnt_reg + {31'd0, cpu_en_int};

        if (cmd_accept && (cmdOp == OP_SETBP)) begin
            if (&bp_arg) begin
                bp_en_next = 1'b0;
            end else begin
                bp_addr_next = bp_arg;
                bp_en_next   = 1'b1;
            end
        end

        case (state_reg)
            ST_HALT: begin
                if (cmd_accept) begin
                    if (cmdOp == OP_RUN) begin
                        state_next    = ST_RUN;
                        bp_armed_next = 1'b0;
                        bp_hit_next   = 1'b0;
                    end else if ((cmdOp == OP_STEP) && (step_arg != '0)) begin
                        state_next     = ST_STEP;
                        step_left_next = step_arg;
                        bp_hit_next    = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (cpu_en_int) begin
                    bp_armed_next = 1'b1;
                end
                // A breakpoint outranks any command arriving in the same cycle.
                if (bp_match) begin
                    state_next  = ST_HALT;
                    bp_hit_next = 1'b1;
                end else if (cmd_accept) begin
                    case (cmdOp)
                        OP_HALT: state_next = ST_HALT;
                        OP_RUN:  bp_armed_next = 1'b0;
                        OP_STEP: begin
                            if (step_arg != '0) begin
                                state_next     = ST_STEP;
                                step_left_next = step_arg;
                            end else begin
                                state_next = ST_HALT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                step_left_next = step_left_reg - 1'b1;
                if (step_left_reg <= 1) begin
                    state_next = ST_HALT;
                end
            end
            default: state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RESET_STATE;
            step_left_reg <= '0;
            bp_addr_reg   <= '0;
            bp_en_reg     <= 1'b0;
            bp_armed_reg  <= 1'b0;
            bp_hit_reg    <= 1'b0;
            cycle_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            step_left_reg <= step_left_next;
            bp_addr_reg   <= bp_addr_next;
            bp_en_reg     <= bp_en_next;
            bp_armed_reg  <= bp_armed_next;
            bp_hit_reg    <= bp_hit_next;
            cycle_cnt_reg <= cycle_cnt_next;
        end
    end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed bench for sm_run_ctrl: a command/expectation table plus hand-written
// sequences for stepping, breakpoints, reset during STEP and counter wrap.
module tb_sm_run_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [31:0] pc;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [31:0] cycle_cnt;

    logic        pc_load;
    logic [31:0] pc_load_val;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_SETBP = 2'b11;

    sm_run_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(16), .RUN_ON_RESET(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmdValid (cmd_valid),
        .cmdReady (cmd_ready),
        .cmdOp    (cmd_op),
        .cmdArg   (cmd_arg),
        .pc       (pc),
        .cpuEn    (cpu_en),
        .halted   (halted),
        .bpHit    (bp_hit),
        .cycleCnt (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal CPU model: PC advances by one word per enabled cycle.
    always @(posedge clk) begin
        if (pc_load)     pc <= pc_load_val;
        else if (cpu_en) pc <= pc + 32'd1;
    end

    typedef struct {
        logic        vld;
        logic [1:0]  op;
        logic [31:0] arg;
        int          w;
        logic        exp_halted;
        logic        exp_en;
        logic        exp_ready;
        logic        exp_hit;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Starts and ends just after a negedge; the command is seen on one posedge.
    task automatic cmd(input logic vld, input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = vld;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_load     = 1'b1;
        pc_load_val = v;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 32'd0;
        @(negedge clk);
        rst     = 1'b0;
        pc_load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int low;

        // op, arg, extra cycles, halted, cpuEn, cmdReady, bpHit, cycleCnt
        vecs[0]  = '{1'b1, OP_HALT,  32'd0,        1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, OP_STEP,  32'd0,        1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[2]  = '{1'b1, OP_STEP,  32'd3,        0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, OP_HALT,  32'd0,        2, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3};
        vecs[4]  = '{1'b1, OP_RUN,   32'd0,        0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3};
        vecs[5]  = '{1'b0, OP_HALT,  32'd0,        3, 1'b0, 1'b1, 1'b1, 1'b0, 32'd7};
        vecs[6]  = '{1'b1, OP_STEP,  32'd2,        0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8};
        vecs[7]  = '{1'b0, OP_HALT,  32'd0,        1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd10};
        vecs[8]  = '{1'b1, OP_RUN,   32'd0,        1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd11};
        vecs[9]  = '{1'b1, OP_HALT,  32'd0,        0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd12};
        vecs[10] = '{1'b1, OP_SETBP, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd12};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = OP_HALT;
        cmd_arg = 32'd0;
        pc_load = 1'b1;
        pc_load_val = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_cpuen", {31'd0, cpu_en}, 32'd0);
        rst = 1'b0;
        pc_load = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_halted", {31'd0, halted}, 32'd1);
        check("reset_cpuen", {31'd0, cpu_en}, 32'd0);
        check("reset_cnt", cycle_cnt, 32'd0);
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_bphit", {31'd0, bp_hit}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            cmd(vecs[i].vld, vecs[i].op, vecs[i].arg);
            repeat (vecs[i].w) @(negedge clk);
            check($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
            check($sformatf("vec%0d_cpuen", i), {31'd0, cpu_en}, {31'd0, vecs[i].exp_en});
            check($sformatf("vec%0d_ready", i), {31'd0, cmd_ready}, {31'd0, vecs[i].exp_ready});
            check($sformatf("vec%0d_bphit", i), {31'd0, bp_hit}, {31'd0, vecs[i].exp_hit});
            check($sformatf("vec%0d_cnt", i), cycle_cnt, vecs[i].exp_cnt);
        end

        // STEP 5: exactly five enabled cycles with the command port closed.
        cmd(1'b1, OP_STEP, 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("step5_c%0d_cpuen", i), {31'd0, cpu_en}, 32'd1);
            check($sformatf("step5_c%0d_ready", i), {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        check("step5_halted", {31'd0, halted}, 32'd1);
        check("step5_cpuen", {31'd0, cpu_en}, 32'd0);
        check("step5_cnt", cycle_cnt, 32'd17);

        // Breakpoint at PC 16, running from PC 0.
        do_reset();
        cmd(1'b1, OP_SETBP, 32'h0000_0010);
        cmd(1'b1, OP_RUN, 32'd0);
        n = 0;
        while (cpu_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_cpuen_drop", {31'd0, cpu_en}, 32'd0);
        check("bp_pc", pc, 32'd16);
        check("bp_not_yet_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        check("bp_halted", {31'd0, halted}, 32'd1);
        check("bp_hit", {31'd0, bp_hit}, 32'd1);
        check("bp_cnt", cycle_cnt, 32'd16);

        // Resume from the breakpoint PC without re-triggering.
        cmd(1'b1, OP_RUN, 32'd0);
        check("resume_cpuen", {31'd0, cpu_en}, 32'd1);
        check("resume_bphit_clr", {31'd0, bp_hit}, 32'd0);
        @(negedge clk);
        check("resume_pc", pc, 32'd17);
        cmd(1'b1, OP_HALT, 32'd0);

        // Disabled breakpoint: run straight through PC 16.
        cmd(1'b1, OP_SETBP, 32'hFFFF_FFFF);
        load_pc(32'd0);
        cmd(1'b1, OP_RUN, 32'd0);
        low = 0;
        repeat (40) begin
            if (!cpu_en) low++;
            @(negedge clk);
        end
        check("bpoff_low_cycles", low, 32'd0);
        check("bpoff_pc", pc, 32'd40);
        check("bpoff_running", {31'd0, halted}, 32'd0);
        cmd(1'b1, OP_HALT, 32'd0);

        // HALT command in the same cycle as the breakpoint match.
        cmd(1'b1, OP_SETBP, 32'h0000_0010);
        load_pc(32'd0);
        cmd(1'b1, OP_RUN, 32'd0);
        n = 0;
        while (cpu_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("coinc_pc", pc, 32'd16);
        cmd(1'b1, OP_HALT, 32'd0);
        check("coinc_halted", {31'd0, halted}, 32'd1);
        check("coinc_bphit", {31'd0, bp_hit}, 32'd1);

        // Asynchronous reset in the middle of STEP 100.
        cmd(1'b1, OP_STEP, 32'd100);
        repeat (10) @(negedge clk);
        check("midstep_cpuen", {31'd0, cpu_en}, 32'd1);
        check("midstep_ready", {31'd0, cmd_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_cpuen", {31'd0, cpu_en}, 32'd0);
        check("arst_stepleft", {16'd0, dut.step_left_reg}, 32'd0);
        check("arst_halted", {31'd0, halted}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_arst_halted", {31'd0, halted}, 32'd1);
        check("post_arst_cpuen", {31'd0, cpu_en}, 32'd0);
        check("post_arst_cnt", cycle_cnt, 32'd0);

        // Counter wrap through 2^32-1.
        force dut.cycle_cnt_reg = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.cycle_cnt_reg;
        check("wrap_preload", cycle_cnt, 32'hFFFF_FFFE);
        cmd(1'b1, OP_STEP, 32'd3);
        repeat (3) @(negedge clk);
        check("wrap_halted", {31'd0, halted}, 32'd1);
        check("wrap_cnt", cycle_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
